// File: rtl/alu_pkg.sv
// Shared definitions for the multi-cycle ALU: opcodes, FSM states,
// iterative datapath modes and opcode classification helpers.
package alu_pkg;

  localparam logic [3:0] ALU_AND  = 4'd0;
  localparam logic [3:0] ALU_XOR  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_ADD  = 4'd3;
  localparam logic [3:0] ALU_SUB  = 4'd4;
  localparam logic [3:0] ALU_MUL  = 4'd5;
  localparam logic [3:0] ALU_ADDI = 4'd6;
  localparam logic [3:0] ALU_SRAI = 4'd7;
  localparam logic [3:0] ALU_DIVU = 4'd8;
  localparam logic [3:0] ALU_REMU = 4'd9;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  typedef enum logic [1:0] {
    MD_MUL,
    MD_DIVU,
    MD_REMU
  } md_mode_t;

  function automatic logic is_multicycle(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

  function automatic logic is_legal(input logic [3:0] op);
    return op <= ALU_REMU;
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// Shared iterative datapath: shift-add multiply and restoring unsigned divide,
// one bit per cycle for WIDTH cycles after a start pulse.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  md_mode_t         mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  // acc: product accumulator / partial remainder
  // opb: multiplicand (shifts left) / divisor (static)
  // sh : multiplier (shifts right) / dividend-in, quotient-out (shifts left)
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d;
  md_mode_t         mode_q, mode_d;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic [WIDTH-1:0] addend;

  assign done_o = busy_q && (cnt_q == CW'(WIDTH - 1));

  always_comb begin
    acc_d   = acc_q;
    opb_d   = opb_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    mode_d  = mode_q;
    shifted = {acc_q, sh_q[WIDTH-1]};
    trial   = shifted - {1'b0, opb_q};
    addend  = sh_q[0] ? opb_q : '0;

    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      mode_d = mode_i;
      acc_d  = '0;
      opb_d  = b_i;
      sh_d   = a_i;
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
      if (done_o) begin
        busy_d = 1'b0;
      end
      if (mode_q == MD_MUL) begin
        acc_d = acc_q + addend;
        opb_d = {opb_q[WIDTH-2:0], 1'b0};
        sh_d  = {1'b0, sh_q[WIDTH-1:1]};
      end else if (!trial[WIDTH]) begin
        // A zero divisor always "fits", giving all-ones quotient and remainder = dividend
        acc_d = trial[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], 1'b1};
      end else begin
        acc_d = shifted[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], 1'b0};
      end
    end

    // Final value is taken from the next-state so the top can latch it on the last edge
    result_o = (mode_q == MD_DIVU) ? sh_d : acc_d;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      acc_q  <= '0;
      opb_q  <= '0;
      sh_q   <= '0;
      cnt_q  <= '0;
      busy_q <= 1'b0;
      mode_q <= MD_MUL;
    end else begin
      acc_q  <= acc_d;
      opb_q  <= opb_d;
      sh_q   <= sh_d;
      cnt_q  <= cnt_d;
      busy_q <= busy_d;
      mode_q <= mode_d;
    end
  end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle execute-stage ALU: valid/ready handshake on both sides,
// single-cycle logic/add/shift ops and iterative MUL/DIVU/REMU.
module alu_mc
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [3:0]       ALUCtrl_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic [WIDTH-1:0] data2_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] data_o,
  output logic             Zero_o,
  output logic             illegal_o
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             zero_q, zero_d;
  logic             ill_q, ill_d;

  logic             md_start;
  md_mode_t         md_mode;
  logic             md_done;
  logic [WIDTH-1:0] md_result;
  logic [WIDTH-1:0] alu_res;
  logic [SHW-1:0]   shamt;

  alu_iter_muldiv #(
    .WIDTH (WIDTH),
    .CW    (SHW)
  ) u_muldiv (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (md_start),
    .mode_i   (md_mode),
    .a_i      (data1_i),
    .b_i      (data2_i),
    .done_o   (md_done),
    .result_o (md_result)
  );

  assign shamt = data2_i[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (ALUCtrl_i)
      ALU_AND:           alu_res = data1_i & data2_i;
      ALU_XOR:           alu_res = data1_i ^ data2_i;
      ALU_SLL:           alu_res = data1_i << shamt;
      ALU_ADD, ALU_ADDI: alu_res = data1_i + data2_i;
      ALU_SUB:           alu_res = data1_i - data2_i;
      ALU_SRAI:          alu_res = WIDTH'($signed(data1_i) >>> shamt);
      default:           alu_res = '0;
    endcase
  end

  always_comb begin
    md_mode = MD_MUL;
    case (ALUCtrl_i)
      ALU_DIVU: md_mode = MD_DIVU;
      ALU_REMU: md_mode = MD_REMU;
      default:  md_mode = MD_MUL;
    endcase
  end

  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    zero_d   = zero_q;
    ill_d    = ill_q;
    md_start = 1'b0;

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          if (!is_legal(ALUCtrl_i)) begin
            state_d = DONE;
            data_d  = '0;
            zero_d  = 1'b1;
            ill_d   = 1'b1;
          end else if (is_multicycle(ALUCtrl_i)) begin
            state_d  = BUSY;
            md_start = 1'b1;
          end else begin
            state_d = DONE;
            data_d  = alu_res;
            zero_d  = (alu_res == '0);
            ill_d   = 1'b0;
          end
        end
      end
      BUSY: begin
        if (md_done) begin
          state_d = DONE;
          data_d  = md_result;
          zero_d  = (md_result == '0);
          ill_d   = 1'b0;
        end
      end
      DONE: begin
        if (ready_i) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      data_q  <= '0;
      zero_q  <= 1'b0;
      ill_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      zero_q  <= zero_d;
      ill_q   <= ill_d;
    end
  end

  assign ready_o   = (state_q == IDLE);
  assign valid_o   = (state_q == DONE);
  assign data_o    = data_q;
  assign Zero_o    = valid_o & zero_q;
  assign illegal_o = valid_o & ill_q;

endmodule

// File: tb/tb_alu_mc.sv
// Self-checking bench for alu_mc: directed corner cases, reset mid-iteration,
// held requests during BUSY and randomized ops against an arithmetic model.
module tb_alu_mc;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_i;
  logic         valid_i;
  logic         ready_o;
  logic [3:0]   ALUCtrl_i;
  logic [W-1:0] data1_i;
  logic [W-1:0] data2_i;
  logic         valid_o;
  logic         ready_i;
  logic [W-1:0] data_o;
  logic         Zero_o;
  logic         illegal_o;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  alu_mc #(.WIDTH(W)) u_dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .valid_i   (valid_i),
    .ready_o   (ready_o),
    .ALUCtrl_i (ALUCtrl_i),
    .data1_i   (data1_i),
    .data2_i   (data2_i),
    .valid_o   (valid_o),
    .ready_i   (ready_i),
    .data_o    (data_o),
    .Zero_o    (Zero_o),
    .illegal_o (illegal_o)
  );

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%h expected 0x%h", tag, got, exp);
    end
  endtask

  // Returns {illegal, result}
  function automatic logic [W:0] model(input logic [3:0] op, input logic [W-1:0] a,
                                       input logic [W-1:0] b);
    logic [W-1:0] r;
    int unsigned  sh;
    sh = b % W;
    case (op)
      4'd0:       r = a & b;
      4'd1:       r = a ^ b;
      4'd2:       r = a << sh;
      4'd3, 4'd6: r = a + b;
      4'd4:       r = a - b;
      4'd5:       r = a * b;
      4'd7:       r = $signed(a) >>> sh;
      4'd8:       r = (b == 0) ? {W{1'b1}} : a / b;
      4'd9:       r = (b == 0) ? a : a % b;
      default:    return {1'b1, {W{1'b0}}};
    endcase
    return {1'b0, r};
  endfunction

  function automatic int exp_lat(input logic [3:0] op);
    return (op == 4'd5 || op == 4'd8 || op == 4'd9) ? W + 1 : 1;
  endfunction

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                              input logic [W-1:0] b, input int lat);
    logic [W:0] e;
    e = model(op, a, b);
    chk({nm, "_lat"}, W'(lat), W'(exp_lat(op)));
    chk({nm, "_valid"}, valid_o, 1);
    chk({nm, "_data"}, data_o, e[W-1:0]);
    chk({nm, "_zero"}, Zero_o, (e[W] || e[W-1:0] == '0) ? 1 : 0);
    chk({nm, "_illegal"}, illegal_o, e[W]);
  endtask

  task automatic release_result(input string nm);
    @(negedge clk);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk({nm, "_rel_valid"}, valid_o, 0);
    chk({nm, "_rel_ready"}, ready_o, 1);
  endtask

  task automatic do_op(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input int hold);
    int lat;
    logic [W:0] e;
    e = model(op, a, b);
    @(negedge clk);
    chk({nm, "_ready_in"}, ready_o, 1);
    ALUCtrl_i = op;
    data1_i   = a;
    data2_i   = b;
    valid_i   = 1'b1;
    @(posedge clk); #1;
    valid_i   = 1'b0;
    ALUCtrl_i = 4'($urandom);
    data1_i   = $urandom;
    data2_i   = $urandom;
    wait_valid(lat);
    check_result(nm, op, a, b, lat);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk({nm, "_hold_data"}, data_o, e[W-1:0]);
      chk({nm, "_hold_valid"}, valid_o, 1);
      chk({nm, "_hold_ready"}, ready_o, 0);
    end
    release_result(nm);
  endtask

  initial begin
    int         lat;
    logic       seen;
    logic [3:0] op;
    logic [W-1:0] a, b;

    rst_i     = 1'b0;
    valid_i   = 1'b0;
    ready_i   = 1'b0;
    ALUCtrl_i = '0;
    data1_i   = '0;
    data2_i   = '0;
    #12;
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_zero", Zero_o, 0);
    chk("rst_illegal", illegal_o, 0);
    @(negedge clk);
    rst_i = 1'b1;

    do_op("add_wrap", 4'd3, 32'hFFFF_FFFF, 32'd1, 0);
    do_op("sub_neg", 4'd4, 32'd5, 32'd7, 0);
    do_op("sll_33", 4'd2, 32'd1, 32'd33, 0);
    do_op("srai", 4'd7, 32'h8000_0000, 32'd4, 0);
    do_op("mul_zero", 4'd5, 32'h0001_0000, 32'h0001_0000, 0);
    do_op("mul_bp", 4'd5, 32'hFFFF_FFFF, 32'd3, 5);
    do_op("divu", 4'd8, 32'd100, 32'd7, 0);
    do_op("remu", 4'd9, 32'd100, 32'd7, 0);
    do_op("divu_z", 4'd8, 32'hDEAD_BEEF, 32'd0, 0);
    do_op("remu_z", 4'd9, 32'h1234, 32'd0, 0);
    do_op("illegal", 4'hC, 32'h55, 32'h66, 2);
    chk("sub_const", model(4'd4, 32'd5, 32'd7), {1'b0, 32'hFFFF_FFFE});
    chk("srai_const", model(4'd7, 32'h8000_0000, 32'd4), {1'b0, 32'hF800_0000});

    // Reset in the middle of a MUL, after a nonzero result left data_o non-zero
    do_op("pre_rst", 4'd3, 32'd5, 32'd6, 0);
    @(negedge clk);
    ALUCtrl_i = 4'd5;
    data1_i   = 32'd7;
    data2_i   = 32'd6;
    valid_i   = 1'b1;
    @(posedge clk); #1;
    valid_i = 1'b0;
    repeat (9) @(posedge clk);
    #2;
    rst_i = 1'b0;
    #1;
    chk("midrst_ready", ready_o, 1);
    chk("midrst_valid", valid_o, 0);
    chk("midrst_data", data_o, 0);
    chk("midrst_zero", Zero_o, 0);
    chk("midrst_illegal", illegal_o, 0);
    @(negedge clk);
    rst_i = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); #1;
      if (valid_o) seen = 1'b1;
    end
    chk("midrst_no_valid", seen, 0);
    do_op("post_rst_add", 4'd3, 32'd1, 32'd2, 0);

    // Request held during BUSY must not disturb the in-flight DIVU
    @(negedge clk);
    ALUCtrl_i = 4'd8;
    data1_i   = 32'd1000;
    data2_i   = 32'd3;
    valid_i   = 1'b1;
    @(posedge clk); #1;
    ALUCtrl_i = 4'd3;
    data1_i   = 32'd10;
    data2_i   = 32'd20;
    repeat (4) @(posedge clk);
    #1;
    chk("held_busy_ready", ready_o, 0);
    lat = 5;
    while (!valid_o && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_result("held_div", 4'd8, 32'd1000, 32'd3, lat);
    ready_i = 1'b1;
    @(posedge clk); #1;
    ready_i = 1'b0;
    chk("held_idle_ready", ready_o, 1);
    chk("held_idle_valid", valid_o, 0);
    @(posedge clk); #1;
    valid_i = 1'b0;
    chk("held_add_valid", valid_o, 1);
    chk("held_add_data", data_o, 32'd30);
    release_result("held_add");

    for (int n = 0; n < 30; n++) begin
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      if ($urandom_range(0, 5) == 0) b = '0;
      else if ($urandom_range(0, 3) == 0) b = W'($urandom_range(1, 40));
      do_op("rand", op, a, b, int'($urandom_range(0, 3)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/alu_mc.md
# alu_mc

Parametrised multi-cycle ALU for the CPU execute stage, replacing the single-cycle combinational ALU. Logic/add/shift ops complete in one registered cycle; MUL, DIVU and REMU run on a shared iterative shift-add / restoring-divide datapath. A valid/ready handshake on both sides lets the pipeline stall while a long op is in flight.

## Interface
- WIDTH, 32: operand and result width (≥ 8, power of two)
- SHW, $clog2(WIDTH): shift-amount bits taken from data2
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous, active-low reset
- valid_i  in  1  operation request
- ready_o  out  1  block can accept a request
- ALUCtrl_i  in  4  opcode, from alu_pkg
- data1_i  in  WIDTH  operand A
- data2_i  in  WIDTH  operand B / immediate
- valid_o  out  1  result valid
- ready_i  in  1  downstream accepts result
- data_o  out  WIDTH  result
- Zero_o  out  1  data_o == 0, qualified by valid_o
- illegal_o  out  1  current result came from an undefined opcode

## Operation
- Opcodes: AND 0, XOR 1, SLL 2, ADD 3, SUB 4, MUL 5, ADDI 6, SRAI 7, DIVU 8, REMU 9; 10–15 are illegal.
- Accept: valid_i && ready_o on a rising edge. Opcode and operands are captured; later input changes are ignored.
- FSM states: IDLE, BUSY, DONE.
  - IDLE -> DONE for single-cycle or illegal ops.
  - IDLE -> BUSY for MUL, DIVU and REMU.
  - BUSY -> DONE once the iteration counter reaches WIDTH-1.
  - DONE -> IDLE when ready_i is high.
- ready_o = (state == IDLE). valid_o = (state == DONE).
- Result arithmetic:
  - All results are modulo 2^WIDTH; no carry or overflow output.
  - SLL and SRAI use data2[SHW-1:0] only. SRAI is arithmetic (sign fill).
  - MUL returns the low WIDTH bits of the unsigned product. These equal the signed low bits.
  - DIVU/REMU are unsigned restoring division, one quotient bit per cycle.
  - Divide by zero: DIVU returns all ones; REMU returns data1. Both still take the full WIDTH iterations.
- Illegal opcode: data_o = 0, Zero_o = 1, illegal_o = 1, latency 1.
- data_o, Zero_o and illegal_o hold stable throughout DONE until accepted.

## Timing
- Reset (rst_i low, any state, including mid-iteration):
  - state = IDLE, counter = 0.
  - ready_o = 1, valid_o = 0, data_o = 0, Zero_o = 0, illegal_o = 0.
  - Takes effect immediately and asynchronously. Release is synchronised by the standard reset path.
- Latency from the accept edge to valid_o high:
  - 1 cycle for single-cycle and illegal ops.
  - WIDTH+1 cycles for MUL, DIVU and REMU.
- Throughput: at most one op per 2 cycles, because there is no accept while in DONE. The result is not forwarded into IDLE in the same cycle.
- Back-pressure: if ready_i stays low, DONE persists indefinitely with outputs frozen.
- valid_i while BUSY or DONE is not accepted. The upstream stage must hold its request.
- ready_i while not in DONE has no effect.

## Structure
- alu_pkg holds:
  - the 4-bit opcode localparams (ALU_AND … ALU_REMU);
  - the state enum {IDLE, BUSY, DONE};
  - the helper function is_multicycle(op).
- Sub-module alu_iter_muldiv holds the shared datapath: accumulator/remainder register, multiplicand/divisor register, quotient/multiplier shift register and iteration counter.
  - Ports: start, mode (mul/divu/remu), a, b, done, result.
  - The top level keeps the FSM, handshake, single-cycle ops and output registers.

## Test plan
- Reset mid-MUL, in this order:
  1. Accept MUL 7×6.
  2. Pull rst_i low at cycle 10.
  3. Required: outputs go to reset values immediately; ready_o = 1; no valid_o afterwards.
  4. A new ADD 1+2 then returns 3 after 1 cycle.
- Single-cycle ops (WIDTH=32):
  - ADD 0xFFFFFFFF+1 -> 0 with Zero_o = 1.
  - SUB 5−7 -> 0xFFFFFFFE.
  - SLL 1<<33 -> 2 (low 5 bits used).
  - SRAI 0x80000000>>>4 -> 0xF8000000.
  - Each arrives 1 cycle after accept.
- MUL and back-pressure:
  - MUL 0x10000×0x10000 -> 0 (Zero_o = 1).
  - MUL 0xFFFFFFFF×3 -> 0xFFFFFFFD.
  - valid_o asserts exactly 33 cycles after accept.
  - Hold ready_i low for 5 cycles: data_o stays stable, ready_o stays 0.
- Division:
  - DIVU 100/7 -> 14 and REMU 100/7 -> 2.
  - DIVU x/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234.
  - All four take 33 cycles.
- Handshake and illegal opcode:
  - Opcode 0xC -> data_o = 0, illegal_o = 1, Zero_o = 1.
  - Assert valid_i with new operands during BUSY: not accepted, in-flight result unchanged.
  - After result acceptance, the held request is accepted the following cycle.
